// File: rtl/washer_pkg.sv
// rtl/washer_pkg.sv - shared washer drum-state encoding and default timing constants
//   Used by washer_plant_model and the washer controller bench.
package washer_pkg;

  typedef enum logic [1:0] {
    DRUM_STOP   = 2'd0,
    DRUM_WASH   = 2'd1,
    DRUM_SPINUP = 2'd2,
    DRUM_SPIN   = 2'd3
  } drum_state_e;

  localparam int DEF_FILL_CYCLES   = 16;
  localparam int DEF_DRY_CYCLES    = 32;
  localparam int DEF_SPINUP_CYCLES = 4;
  localparam int DEF_LEAK_PERIOD   = 64;

endpackage

// File: rtl/plant_sat_counter.sv
// rtl/plant_sat_counter.sv - up/down counter saturating at 0 and MAX, with load
//   clk, rst_n  : clock, asynchronous active-low reset (count -> 0)
//   i_load      : load i_load_val (clamped to MAX); has priority over inc/dec
//   i_inc/i_dec : step up/down by one; both together hold
//   o_count     : registered count
module plant_sat_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;

  always_comb begin
    w_next = r_count;
    if (i_load) begin
      w_next = (i_load_val > MAX_V) ? MAX_V : i_load_val;
    end else if (i_inc && !i_dec && (r_count < MAX_V)) begin
      w_next = r_count + 1'b1;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      w_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/washer_plant_model.sv
// rtl/washer_plant_model.sv - cycle-counted washer plant model (water level, moisture, drum)
//   Optional build macro: PLANT_LEAK_EN (periodic one-step level leak).
//   Inputs : clk, rst_n (async active-low), water_fill, motor_wash, motor_spin,
//            drain, clr_illegal
//   Outputs: water_full, drained, dry_sensor, level, drum_state, illegal
//            (all decoded from registers only)
module washer_plant_model
  import washer_pkg::*;
#(
  parameter  int FILL_CYCLES   = DEF_FILL_CYCLES,
  parameter  int DRY_CYCLES    = DEF_DRY_CYCLES,
  parameter  int SPINUP_CYCLES = DEF_SPINUP_CYCLES,
  parameter  int LEAK_PERIOD   = DEF_LEAK_PERIOD,
  localparam int LEVEL_W       = $clog2(FILL_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               water_fill,
  input  logic               motor_wash,
  input  logic               motor_spin,
  input  logic               drain,
  input  logic               clr_illegal,
  output logic               water_full,
  output logic               drained,
  output logic               dry_sensor,
  output logic [LEVEL_W-1:0] level,
  output logic [1:0]         drum_state,
  output logic               illegal
);

  localparam int MOIST_W = $clog2(DRY_CYCLES + 1);
  localparam int SPIN_W  = $clog2(SPINUP_CYCLES + 1);

  localparam logic [LEVEL_W-1:0] FILL_V    = LEVEL_W'(FILL_CYCLES);
  localparam logic [MOIST_W-1:0] DRY_V     = MOIST_W'(DRY_CYCLES);
  localparam logic [SPIN_W-1:0]  SPIN_LAST = SPIN_W'(SPINUP_CYCLES - 1);

  if (FILL_CYCLES < 1) begin : g_chk_fill
    $error("FILL_CYCLES must be >= 1");
  end
  if (DRY_CYCLES < 1) begin : g_chk_dry
    $error("DRY_CYCLES must be >= 1");
  end
  if (SPINUP_CYCLES < 1) begin : g_chk_spinup
    $error("SPINUP_CYCLES must be >= 1");
  end
  if (LEAK_PERIOD < 1) begin : g_chk_leak
    $error("LEAK_PERIOD must be >= 1");
  end

  logic [LEVEL_W-1:0] w_level;
  logic [MOIST_W-1:0] w_moist;
  logic               w_lvl_inc;
  logic               w_lvl_dec_cmd;
  logic               w_leak_dec;
  logic               w_conflict;

  // ---------------- water level ----------------
  // Increment/decrement qualified by the saturation limits here so that the
  // leak can tell whether the command rule produced a change this cycle.
  assign w_lvl_inc     = water_fill & ~drain & (w_level < FILL_V);
  assign w_lvl_dec_cmd = drain & ~water_fill & (w_level != '0);

`ifdef PLANT_LEAK_EN
  localparam int LEAK_W = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;

  logic [LEAK_W-1:0] r_leak_cnt;
  logic              w_leak_wrap;

  assign w_leak_wrap = (r_leak_cnt == LEAK_W'(LEAK_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_leak_cnt <= '0;
    end else if (w_leak_wrap) begin
      r_leak_cnt <= '0;
    end else begin
      r_leak_cnt <= r_leak_cnt + 1'b1;
    end
  end

  // Leak only steps when commands leave the level unchanged: drain already
  // decrementing or fill incrementing both suppress it.
  assign w_leak_dec = w_leak_wrap & (w_level != '0) & ~w_lvl_inc & ~w_lvl_dec_cmd;
`else
  assign w_leak_dec = 1'b0;
`endif

  plant_sat_counter #(
    .W   (LEVEL_W),
    .MAX (FILL_CYCLES)
  ) u_level (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_lvl_inc),
    .i_dec      (w_lvl_dec_cmd | w_leak_dec),
    .o_count    (w_level)
  );

  // ---------------- moisture ----------------
  // Any water in the drum re-wets the load; drying happens only at speed.
  drum_state_e r_drum;
  drum_state_e w_drum_next;

  plant_sat_counter #(
    .W   (MOIST_W),
    .MAX (DRY_CYCLES)
  ) u_moisture (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_level != '0),
    .i_load_val (DRY_V),
    .i_inc      (1'b0),
    .i_dec      (r_drum == DRUM_SPIN),
    .o_count    (w_moist)
  );

  // ---------------- drum FSM ----------------
  logic [SPIN_W-1:0] r_spin_cnt;
  logic [SPIN_W-1:0] w_spin_cnt_next;
  logic [SPIN_W-1:0] w_spin_cnt_inc;

  // The entry edge from STOP/WASH counts as the first spin-up cycle, so SPIN
  // is reached SPINUP_CYCLES edges after spin is first sampled.
  assign w_spin_cnt_inc = r_spin_cnt + 1'b1;

  always_comb begin
    w_drum_next     = r_drum;
    w_spin_cnt_next = r_spin_cnt;
    if (motor_wash && motor_spin) begin
      w_drum_next = DRUM_STOP;
    end else begin
      case (r_drum)
        DRUM_STOP: begin
          if (motor_wash) begin
            w_drum_next = DRUM_WASH;
          end else if (motor_spin) begin
            w_spin_cnt_next = '0;
            w_drum_next     = (SPINUP_CYCLES == 1) ? DRUM_SPIN : DRUM_SPINUP;
          end
        end
        DRUM_WASH: begin
          if (motor_spin) begin
            w_spin_cnt_next = '0;
            w_drum_next     = (SPINUP_CYCLES == 1) ? DRUM_SPIN : DRUM_SPINUP;
          end else if (!motor_wash) begin
            w_drum_next = DRUM_STOP;
          end
        end
        DRUM_SPINUP: begin
          if (motor_spin) begin
            w_spin_cnt_next = w_spin_cnt_inc;
            if (w_spin_cnt_inc >= SPIN_LAST) begin
              w_drum_next = DRUM_SPIN;
            end
          end else begin
            w_drum_next = motor_wash ? DRUM_WASH : DRUM_STOP;
          end
        end
        DRUM_SPIN: begin
          if (!motor_spin) begin
            w_drum_next = motor_wash ? DRUM_WASH : DRUM_STOP;
          end
        end
        default: w_drum_next = DRUM_STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drum     <= DRUM_STOP;
      r_spin_cnt <= '0;
    end else begin
      r_drum     <= w_drum_next;
      r_spin_cnt <= w_spin_cnt_next;
    end
  end

  // ---------------- sticky illegal ----------------
  logic r_illegal;

  assign w_conflict = (water_fill & drain) | (motor_wash & motor_spin);

  // A conflict outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_conflict) begin
      r_illegal <= 1'b1;
    end else if (clr_illegal) begin
      r_illegal <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  assign level      = w_level;
  assign water_full = (w_level == FILL_V);
  assign drained    = (w_level == '0);
  assign dry_sensor = (w_moist == '0);
  assign drum_state = r_drum;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_washer_plant_model.sv
// tb/tb_washer_plant_model.sv - directed self-checking bench for washer_plant_model
module tb_washer_plant_model;

  localparam int FILL   = 16;
  localparam int DRY    = 32;
  localparam int SPINUP = 4;
  localparam int LEAKP  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       water_fill = 1'b0;
  logic       motor_wash = 1'b0;
  logic       motor_spin = 1'b0;
  logic       drain = 1'b0;
  logic       clr_illegal = 1'b0;
  logic       water_full;
  logic       drained;
  logic       dry_sensor;
  logic [4:0] level;
  logic [1:0] drum_state;
  logic       illegal;

  int checks = 0;
  int failures = 0;

  washer_plant_model #(
    .FILL_CYCLES   (FILL),
    .DRY_CYCLES    (DRY),
    .SPINUP_CYCLES (SPINUP),
    .LEAK_PERIOD   (LEAKP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .water_fill  (water_fill),
    .motor_wash  (motor_wash),
    .motor_spin  (motor_spin),
    .drain       (drain),
    .clr_illegal (clr_illegal),
    .water_full  (water_full),
    .drained     (drained),
    .dry_sensor  (dry_sensor),
    .level       (level),
    .drum_state  (drum_state),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    water_fill  = 1'b0;
    motor_wash  = 1'b0;
    motor_spin  = 1'b0;
    drain       = 1'b0;
    clr_illegal = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++;
    if (drained !== 1'b1) begin failures++; $display("FAIL reset_drained got=%b exp=1", drained); end
    checks++;
    if (water_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", water_full); end
    checks++;
    if (dry_sensor !== 1'b1) begin failures++; $display("FAIL reset_dry got=%b exp=1", dry_sensor); end
    checks++;
    if (drum_state !== 2'd0) begin failures++; $display("FAIL reset_drum got=%0d exp=0", drum_state); end
    checks++;
    if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    water_fill = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (level !== 5'((i > FILL) ? FILL : i)) begin
        failures++; $display("FAIL fill_level edge=%0d got=%0d exp=%0d", i, level, (i > FILL) ? FILL : i);
      end
      checks++;
      if (water_full !== (i >= FILL)) begin
        failures++; $display("FAIL fill_full edge=%0d got=%b exp=%b", i, water_full, i >= FILL);
      end
      checks++;
      if (drained !== 1'b0) begin
        failures++; $display("FAIL fill_drained edge=%0d got=%b exp=0", i, drained);
      end
    end
    water_fill = 1'b0;
    checks++;
    if (dry_sensor !== 1'b0) begin failures++; $display("FAIL fill_wet got=%b exp=0", dry_sensor); end
  endtask

  task automatic test_drain();
    drain = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      checks++;
      if (level !== 5'((i >= FILL) ? 0 : FILL - i)) begin
        failures++; $display("FAIL drain_level edge=%0d got=%0d exp=%0d", i, level, (i >= FILL) ? 0 : FILL - i);
      end
      checks++;
      if (drained !== (i >= FILL)) begin
        failures++; $display("FAIL drain_drained edge=%0d got=%b exp=%b", i, drained, i >= FILL);
      end
      checks++;
      if (water_full !== 1'b0) begin
        failures++; $display("FAIL drain_full edge=%0d got=%b exp=0", i, water_full);
      end
    end
    drain = 1'b0;
    tick();
    checks++;
    if (dry_sensor !== 1'b0) begin failures++; $display("FAIL drain_wet got=%b exp=0", dry_sensor); end
  endtask

  task automatic test_spin_dry();
    // aborted spin-up returns to STOP without drying
    motor_spin = 1'b1;
    tick();
    checks++;
    if (drum_state !== 2'd2) begin failures++; $display("FAIL abort_spinup got=%0d exp=2", drum_state); end
    tick();
    motor_spin = 1'b0;
    tick();
    checks++;
    if (drum_state !== 2'd0) begin failures++; $display("FAIL abort_stop got=%0d exp=0", drum_state); end
    checks++;
    if (dry_sensor !== 1'b0) begin failures++; $display("FAIL abort_wet got=%b exp=0", dry_sensor); end
    // full spin-up then drying
    motor_spin = 1'b1;
    for (int i = 1; i <= SPINUP; i++) begin
      tick();
      checks++;
      if (drum_state !== ((i == SPINUP) ? 2'd3 : 2'd2)) begin
        failures++; $display("FAIL spinup edge=%0d got=%0d exp=%0d", i, drum_state, (i == SPINUP) ? 3 : 2);
      end
    end
    for (int i = 1; i <= DRY; i++) begin
      tick();
      checks++;
      if (dry_sensor !== (i >= DRY)) begin
        failures++; $display("FAIL dry edge=%0d got=%b exp=%b", i, dry_sensor, i >= DRY);
      end
    end
    checks++;
    if (drum_state !== 2'd3) begin failures++; $display("FAIL spin_hold got=%0d exp=3", drum_state); end
    // wash+spin conflict in SPIN
    motor_wash = 1'b1;
    tick();
    idle();
    checks++;
    if (drum_state !== 2'd0) begin failures++; $display("FAIL conflict_drum got=%0d exp=0", drum_state); end
    checks++;
    if (illegal !== 1'b1) begin failures++; $display("FAIL conflict_drum_illegal got=%b exp=1", illegal); end
    clr_illegal = 1'b1;
    tick();
    clr_illegal = 1'b0;
    checks++;
    if (illegal !== 1'b0) begin failures++; $display("FAIL clr_illegal got=%b exp=0", illegal); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_st [0:8];
    logic       wash_v [0:8];
    logic       spin_v [0:8];
    // STOP->WASH->SPINUP(x3)->SPIN->WASH->SPINUP->WASH->STOP
    exp_st = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd1, 2'd2, 2'd1, 2'd0};
    wash_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    spin_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      motor_wash = wash_v[i];
      motor_spin = spin_v[i];
      tick();
      checks++;
      if (drum_state !== exp_st[i]) begin
        failures++; $display("FAIL drum_seq step=%0d got=%0d exp=%0d", i, drum_state, exp_st[i]);
      end
    end
    idle();
  endtask

  task automatic test_conflict();
    water_fill = 1'b1;
    repeat (5) tick();
    drain = 1'b1;
    tick();
    checks++;
    if (level !== 5'd5) begin failures++; $display("FAIL fd_level got=%0d exp=5", level); end
    checks++;
    if (illegal !== 1'b1) begin failures++; $display("FAIL fd_illegal got=%b exp=1", illegal); end
    idle();
    clr_illegal = 1'b1;
    tick();
    checks++;
    if (illegal !== 1'b0) begin failures++; $display("FAIL fd_clr got=%b exp=0", illegal); end
    water_fill = 1'b1;
    drain = 1'b1;
    tick();
    checks++;
    if (illegal !== 1'b1) begin failures++; $display("FAIL clr_vs_conflict got=%b exp=1", illegal); end
    checks++;
    if (level !== 5'd5) begin failures++; $display("FAIL clr_vs_conflict_level got=%0d exp=5", level); end
    water_fill = 1'b0;
    drain = 1'b0;
    tick();
    clr_illegal = 1'b0;
    checks++;
    if (illegal !== 1'b0) begin failures++; $display("FAIL clr_after got=%b exp=0", illegal); end
  endtask

  task automatic test_reset_midfill();
    water_fill = 1'b1;
    motor_wash = 1'b1;
    repeat (4) tick();
    checks++;
    if (level !== 5'd9) begin failures++; $display("FAIL midfill_level got=%0d exp=9", level); end
    checks++;
    if (drum_state !== 2'd1) begin failures++; $display("FAIL midfill_drum got=%0d exp=1", drum_state); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (level !== 5'd0) begin failures++; $display("FAIL async_level got=%0d exp=0", level); end
    checks++;
    if (drained !== 1'b1) begin failures++; $display("FAIL async_drained got=%b exp=1", drained); end
    checks++;
    if (drum_state !== 2'd0) begin failures++; $display("FAIL async_drum got=%0d exp=0", drum_state); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef PLANT_LEAK_EN
  task automatic test_leak();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    water_fill = 1'b1;
    for (int i = 1; i <= 16; i++) tick();
    water_fill = 1'b0;
    checks++;
    if (level !== 5'd16) begin failures++; $display("FAIL leak_fill got=%0d exp=16", level); end
    for (int i = 17; i <= 32; i++) begin
      tick();
      checks++;
      if (level !== 5'(16 - ((i >= 24) ? 1 : 0) - ((i >= 32) ? 1 : 0))) begin
        failures++; $display("FAIL leak_idle edge=%0d got=%0d", i, level);
      end
    end
    drain = 1'b1;
    for (int i = 33; i <= 41; i++) begin
      tick();
      checks++;
      if (level !== 5'(14 - (i - 32))) begin
        failures++; $display("FAIL leak_drain edge=%0d got=%0d exp=%0d", i, level, 14 - (i - 32));
      end
    end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_spin_dry();
    test_back_to_back();
    test_conflict();
    test_reset_midfill();
`ifdef PLANT_LEAK_EN
    test_leak();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
